px_vram_arbiter: RTL and testbench

PX_VRAM_ARBITER -- requirements
Module: px_vram_arbiter

---
 rtl/px_vram_pkg.sv | 19 +
 rtl/px_vram_arbiter_fill.sv | 113 +++++++++++
 rtl/px_vram_arbiter.sv | 145 ++++++++++++++
 tb/tb_px_vram_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/px_vram_pkg.sv
// Shared defaults and FSM state encodings for the pixel VRAM arbiter slice.
package px_vram_pkg;

    localparam int unsigned PX_ADDR_W   = 17;
    localparam int unsigned PX_DATA_W   = 24;
    localparam int unsigned PX_FB_WORDS = 76800;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } cpu_state_e;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } fill_state_e;

endpackage

// File: rtl/px_vram_arbiter_fill.sv
// Rectangle-free linear fill engine: writes a colour over a wrapping span of the
// framebuffer, one word per cycle whenever the arbiter reports the port is free.
module px_fill_engine
    import px_vram_pkg::*;
#(
    parameter int unsigned ADDR_W   = PX_ADDR_W,
    parameter int unsigned DATA_W   = PX_DATA_W,
    parameter int unsigned FB_WORDS = PX_FB_WORDS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic [DATA_W-1:0] color_i,
    input  logic              slot_free_i,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
    localparam logic [ADDR_W-1:0] MAX_LEN   = ADDR_W'(FB_WORDS);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] len_clamped_c;
    logic [ADDR_W-1:0] addr_next_c;
    logic              accept_c;
    logic              fire_c;
    logic              last_c;

    assign len_clamped_c = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign addr_next_c   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    assign accept_c      = (state_q == F_IDLE) && start_i;
    assign fire_c        = wr_req_o && slot_free_i;
    assign last_c        = (cnt_q == ADDR_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= F_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a zero-length command completes without entering F_RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            F_IDLE:  if (accept_c && (len_clamped_c != '0)) state_d = F_RUN;
            F_RUN:   if (fire_c && last_c) state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        wr_req_o = 1'b0;
        busy_o   = 1'b0;
        unique case (state_q)
            F_RUN:   begin
                wr_req_o = 1'b1;
                busy_o   = 1'b1;
            end
            default: ;
        endcase
    end

    // Address / remaining-count / colour datapath
    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        done_d  = 1'b0;
        if (accept_c) begin
            addr_d  = base_i;
            cnt_d   = len_clamped_c;
            color_d = color_i;
            done_d  = (len_clamped_c == '0);
        end else if (fire_c) begin
            addr_d  = addr_next_c;
            cnt_d   = cnt_q - ADDR_W'(1);
            done_d  = last_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            done_q  <= done_d;
        end
    end

    assign wr_addr_o = addr_q;
    assign wr_data_o = color_q;
    assign done_o    = done_q;

endmodule

// File: rtl/px_vram_arbiter.sv
// Single-port pixel VRAM arbiter: display reads beat CPU accesses, which beat
// fill-engine writes; one VRAM access per cycle.
module px_vram_arbiter
    import px_vram_pkg::*;
#(
    parameter int unsigned ADDR_W   = PX_ADDR_W,
    parameter int unsigned DATA_W   = PX_DATA_W,
    parameter int unsigned FB_WORDS = PX_FB_WORDS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_q,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_ack,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_d,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_q
);

    cpu_state_e        cpu_state_q, cpu_state_d;
    logic              cpu_grant_c;
    logic              cpu_capture_c;
    logic [DATA_W-1:0] cpu_q_q, cpu_q_d;

    logic              fill_req_c;
    logic [ADDR_W-1:0] fill_addr_c;
    logic [DATA_W-1:0] fill_data_c;
    logic              slot_free_c;
    logic              fill_grant_c;

    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] d_hold_q;

    // Display data is the VRAM output one cycle after the address was presented
    assign disp_q = vram_q;

    // CPU state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpu_state_q <= IDLE;
        end else begin
            cpu_state_q <= cpu_state_d;
        end
    end

    // CPU next-state
    always_comb begin
        cpu_state_d = cpu_state_q;
        unique case (cpu_state_q)
            IDLE:    if (cpu_grant_c) cpu_state_d = cpu_we ? ACK : RD_WAIT;
            RD_WAIT: cpu_state_d = ACK;
            ACK:     cpu_state_d = IDLE;
            default: cpu_state_d = IDLE;
        endcase
    end

    // CPU outputs; grants are suppressed while reset is asserted so no write slips out
    always_comb begin
        cpu_grant_c   = 1'b0;
        cpu_capture_c = 1'b0;
        unique case (cpu_state_q)
            IDLE:    cpu_grant_c   = resetn && cpu_req && !disp_req;
            RD_WAIT: cpu_capture_c = 1'b1;
            default: ;
        endcase
    end

    assign cpu_ack = (cpu_state_q == ACK);
    assign cpu_q_d = cpu_capture_c ? vram_q : cpu_q_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpu_q_q <= '0;
        end else begin
            cpu_q_q <= cpu_q_d;
        end
    end

    assign cpu_q = cpu_q_q;

    // Fill only gets slots nobody else wants
    assign slot_free_c  = resetn && !disp_req && !cpu_grant_c;
    assign fill_grant_c = fill_req_c && slot_free_c;

    px_fill_engine #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FB_WORDS (FB_WORDS)
    ) u_fill (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (fill_start),
        .base_i      (fill_base),
        .len_i       (fill_len),
        .color_i     (fill_color),
        .slot_free_i (slot_free_c),
        .wr_req_o    (fill_req_c),
        .wr_addr_o   (fill_addr_c),
        .wr_data_o   (fill_data_c),
        .busy_o      (fill_busy),
        .done_o      (fill_done)
    );

    // VRAM port mux; idle cycles keep the previous address and data on the bus
    always_comb begin
        vram_addr = addr_hold_q;
        vram_d    = d_hold_q;
        vram_we   = 1'b0;
        if (disp_req) begin
            vram_addr = disp_addr;
        end else if (cpu_grant_c) begin
            vram_addr = cpu_addr;
            vram_d    = cpu_data;
            vram_we   = cpu_we;
        end else if (fill_grant_c) begin
            vram_addr = fill_addr_c;
            vram_d    = fill_data_c;
            vram_we   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_hold_q <= '0;
            d_hold_q    <= '0;
        end else begin
            addr_hold_q <= vram_addr;
            d_hold_q    <= vram_d;
        end
    end

endmodule

// File: tb/tb_px_vram_arbiter.sv
// Directed + randomized bench for px_vram_arbiter with a behavioural VRAM and
// arithmetic expectations for fill spans, CPU accesses and display reads.
`timescale 1ns/1ps
module tb_px_vram_arbiter;

    localparam int unsigned AW  = 17;
    localparam int unsigned DW  = 24;
    localparam int unsigned FBW = 76800;

    logic          clk = 1'b0;
    logic          resetn;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_q;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data, cpu_q;
    logic          cpu_ack;
    logic          fill_start;
    logic [AW-1:0] fill_base, fill_len;
    logic [DW-1:0] fill_color;
    logic          fill_busy, fill_done;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_d, vram_q;
    logic          vram_we;

    always #5 clk = ~clk;

    px_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW)) dut (
        .clk(clk), .resetn(resetn),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_q(disp_q),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
        .vram_addr(vram_addr), .vram_d(vram_d), .vram_we(vram_we), .vram_q(vram_q)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural single-port VRAM: unwritten words return an address hash
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            wr_flag [0:(1<<AW)-1];
    int unsigned   seed = 32'h5eed_1234;

    function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
        return wr_flag[a] ? mem[a] : DW'((32'(a) * 32'h9E3779B1) ^ seed);
    endfunction

    always @(posedge clk) begin
        vram_q <= peek(vram_addr);
        if (vram_we === 1'b1) begin
            mem[vram_addr]     <= vram_d;
            wr_flag[vram_addr] <= 1'b1;
        end
    end

    // Write log and pulse counters
    logic [AW-1:0] wlog_a [$];
    logic [DW-1:0] wlog_d [$];
    int disp_wr_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            wlog_a.push_back(vram_addr);
            wlog_d.push_back(vram_d);
            if (disp_req) disp_wr_cnt++;
        end
        if (fill_done === 1'b1) done_cnt++;
    end

    // Display master: 0 off, 1 random, 2 alternate, 3 held high
    int            disp_mode = 0;
    logic          disp_pend = 1'b0;
    logic [DW-1:0] disp_exp = '0;

    always begin
        @(posedge clk); #2;
        case (disp_mode)
            1:       disp_req = 1'($urandom_range(0, 1));
            2:       disp_req = ~disp_req;
            3:       disp_req = 1'b1;
            default: disp_req = 1'b0;
        endcase
        disp_addr = AW'($urandom_range(0, 1023));
        @(negedge clk); #2;
        if (disp_pend) chk("disp_q", disp_q, disp_exp);
        disp_pend = disp_req;
        if (disp_req) begin
            disp_exp = peek(disp_addr);
            chk("disp_vram_addr", vram_addr, disp_addr);
            chk("disp_vram_we", vram_we, 1'b0);
        end
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic clear_log();
        wlog_a.delete();
        wlog_d.delete();
        disp_wr_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] q, output int lat, output logic g_we,
                          output logic [AW-1:0] g_a, output logic [DW-1:0] g_d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_data = d; lat = 0;
        mid();
        g_we = vram_we; g_a = vram_addr; g_d = vram_d;
        while (cpu_ack !== 1'b1 && lat < 40) begin
            next_cycle(); mid(); lat++;
        end
        chk("cpu_ack_seen", cpu_ack, 1'b1);
        q = cpu_q;
        next_cycle();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic run_fill(input logic [AW-1:0] b, input logic [AW-1:0] n,
                            input logic [DW-1:0] c, output int lat);
        fill_base = b; fill_len = n; fill_color = c; fill_start = 1'b1; lat = 0;
        mid();
        chk("fill_busy_at_start", fill_busy, 1'b0);
        next_cycle(); fill_start = 1'b0; lat = 1;
        mid();
        if (n != '0) chk("fill_busy_running", fill_busy, 1'b1);
        while (fill_done !== 1'b1 && lat < 1000) begin
            next_cycle(); mid(); lat++;
        end
        chk("fill_done_seen", fill_done, 1'b1);
        chk("fill_busy_at_done", fill_busy, 1'b0);
        next_cycle();
    endtask

    // Expected span: n consecutive words from base, wrapping at the framebuffer end
    task automatic check_fill_log(input string tag, input logic [AW-1:0] b, input int n,
                                  input logic [DW-1:0] c);
        chk({tag, "_count"}, 64'(wlog_a.size()), 64'(n));
        for (int i = 0; i < n && i < wlog_a.size(); i++) begin
            chk({tag, "_addr"}, wlog_a[i], 64'((32'(b) + 32'(i)) % FBW));
            chk({tag, "_data"}, wlog_d[i], c);
        end
    endtask

    logic [DW-1:0] q, c, last_rd;
    logic [AW-1:0] b, a, ra, ga;
    logic [DW-1:0] gd;
    logic          gwe;
    int            lat, n;
    logic [DW-1:0] sh [int unsigned];
    logic [AW-1:0] keys [$];

    initial begin
        #1000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00055; cpu_data = 24'h777777;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_color = '0;
        next_cycle(); next_cycle();
        mid();
        chk("rst_cpu_ack", cpu_ack, 1'b0);
        chk("rst_fill_busy", fill_busy, 1'b0);
        chk("rst_fill_done", fill_done, 1'b0);
        chk("rst_vram_we", vram_we, 1'b0);
        chk("rst_cpu_q", cpu_q, '0);
        chk("rst_vram_addr", vram_addr, '0);
        chk("rst_vram_d", vram_d, '0);
        next_cycle(); resetn = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        mid();
        chk("post_rst_we", vram_we, 1'b0);
        next_cycle();

        // CPU write then read-back, no display traffic
        cpu_op(1'b1, 17'h00010, 24'h123456, q, lat, gwe, ga, gd);
        chk("wr_grant_we", gwe, 1'b1);
        chk("wr_grant_addr", ga, 17'h00010);
        chk("wr_grant_d", gd, 24'h123456);
        chk("wr_ack_lat", 64'(lat), 64'd1);
        cpu_op(1'b0, 17'h00010, 24'h0, q, lat, gwe, ga, gd);
        chk("rd_grant_we", gwe, 1'b0);
        chk("rd_grant_addr", ga, 17'h00010);
        chk("rd_data", q, 24'h123456);
        chk("rd_ack_lat", 64'(lat), 64'd2);
        mid();
        chk("idle_we", vram_we, 1'b0);
        chk("idle_addr_hold", vram_addr, 17'h00010);
        chk("cpu_q_hold", cpu_q, 24'h123456);
        next_cycle();

        // Display held high for 10 cycles blocks a pending CPU write
        disp_mode = 3; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00200; cpu_data = 24'hABCDEF;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            mid();
            chk("hold_no_grant", vram_we, 1'b0);
            chk("hold_no_ack", cpu_ack, 1'b0);
        end
        next_cycle(); disp_mode = 0;
        mid();
        chk("hold_grant_we", vram_we, 1'b1);
        chk("hold_grant_addr", vram_addr, 17'h00200);
        next_cycle();
        mid();
        chk("hold_ack", cpu_ack, 1'b1);
        next_cycle(); cpu_req = 1'b0; cpu_we = 1'b0;
        next_cycle();

        // Short fill across the framebuffer wrap point
        clear_log();
        run_fill(17'h12BFE, 17'd4, 24'hFF0000, lat);
        chk("fill4_done_lat", 64'(lat), 64'd5);
        check_fill_log("fill4", 17'h12BFE, 4, 24'hFF0000);
        chk("fill4_done_once", 64'(done_cnt), 64'd1);

        // 100-word fill with display taking every other cycle
        b = AW'($urandom_range(FBW - 60, FBW - 1));
        c = DW'($urandom);
        clear_log();
        disp_mode = 2;
        run_fill(b, 17'd100, c, lat);
        disp_mode = 0;
        next_cycle(); next_cycle();
        check_fill_log("fill100", b, 100, c);
        chk("fill100_disp_overlap", 64'(disp_wr_cnt), 64'd0);
        chk("fill100_done_once", 64'(done_cnt), 64'd1);

        // Zero-length fill
        clear_log();
        run_fill(17'h00100, 17'd0, 24'h00FF00, lat);
        chk("len0_done_lat", 64'(lat), 64'd1);
        mid();
        chk("len0_done_pulse", fill_done, 1'b0);
        chk("len0_writes", 64'(wlog_a.size()), 64'd0);
        next_cycle();

        // Restart while running is ignored
        b = AW'($urandom_range(0, FBW - 1));
        c = DW'($urandom);
        clear_log();
        fill_base = b; fill_len = 17'd20; fill_color = c; fill_start = 1'b1;
        next_cycle(); fill_start = 1'b0;
        next_cycle(); next_cycle();
        fill_base = b + 17'd7; fill_len = 17'd5; fill_color = ~c; fill_start = 1'b1;
        mid();
        chk("ign_busy", fill_busy, 1'b1);
        next_cycle(); fill_start = 1'b0; n = 0;
        mid();
        while (fill_done !== 1'b1 && n < 100) begin
            next_cycle(); mid(); n++;
        end
        chk("ign_done_seen", fill_done, 1'b1);
        next_cycle(); next_cycle();
        check_fill_log("fill_ign", b, 20, c);
        chk("ign_done_once", 64'(done_cnt), 64'd1);

        // Reset half-way through a fill
        b = AW'($urandom_range(0, FBW - 1));
        clear_log();
        fill_base = b; fill_len = 17'd100; fill_color = 24'h0000FF; fill_start = 1'b1;
        next_cycle(); fill_start = 1'b0; n = 0;
        mid();
        while (wlog_a.size() < 50 && n < 200) begin
            next_cycle(); mid(); n++;
        end
        chk("abort_reached50", 64'(wlog_a.size()), 64'd50);
        next_cycle(); resetn = 1'b0;
        mid();
        chk("abort_rst_we", vram_we, 1'b0);
        next_cycle(); resetn = 1'b1;
        mid();
        chk("abort_busy", fill_busy, 1'b0);
        repeat (10) next_cycle();
        mid();
        chk("abort_writes", 64'(wlog_a.size()), 64'd50);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        next_cycle();

        // Reset during a CPU read wait: no ack afterwards
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00010;
        next_cycle(); cpu_req = 1'b0; resetn = 1'b0;
        next_cycle(); resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("cpu_abort_no_ack", cpu_ack, 1'b0);
            next_cycle();
        end

        // Random CPU traffic against random display load
        disp_mode = 1;
        last_rd = '0;
        for (int k = 0; k < 16; k++) begin
            a = AW'(17'h003E0 + 17'($urandom_range(0, 31)));
            c = DW'($urandom);
            cpu_op(1'b1, a, c, q, lat, gwe, ga, gd);
            if (k > 0) chk("rand_cpu_q_hold", cpu_q, last_rd);
            sh[32'(a)] = c;
            keys.push_back(a);
            ra = keys[$urandom_range(0, keys.size() - 1)];
            cpu_op(1'b0, ra, '0, q, lat, gwe, ga, gd);
            chk("rand_rd", q, sh[32'(ra)]);
            last_rd = q;
        end
        disp_mode = 0;
        repeat (3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
